// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder.
//
// One full-adder cell consumes the operands LSB-first, one bit per clock,
// with the carry held in a flop between bits. A start/busy/done handshake
// frames each operation. The result is registered and held until the next
// completion.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; abandons any operation in flight
//   start  request a new addition; sampled only in IDLE or DONE
//   a, b   WIDTH-bit addends, captured on an accepted start
//   cin    carry-in, captured on an accepted start
//   busy   high while bits are being shifted through the cell (SHIFT)
//   done   one-cycle pulse; sum/cout are valid from this cycle on
//   sum    registered WIDTH-bit result
//   cout   registered carry-out, held alongside sum

// Single-bit full-adder cell shared by every bit position in time.
module serial_adder_fa (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] sha, shb, acc;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             bit_s, bit_co;
   logic             accept, last;

   serial_adder_fa u_fa (
      .x  (sha[0]),
      .y  (shb[0]),
      .ci (carry),
      .s  (bit_s),
      .co (bit_co)
   );

   // The final bit is processed while cnt holds WIDTH-1; the counter only
   // needs to reach that value, so clog2(WIDTH) bits never wrap early.
   assign last = (cnt == CW'(WIDTH - 1));

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            if (last) state_nx = DONE;
         end
         DONE: begin
            // A start in the done cycle chains straight into the next add.
            if (start) begin
               accept   = 1'b1;
               state_nx = SHIFT;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sha   <= '0;
         shb   <= '0;
         acc   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         // Flags are decoded from the next state so they are flop outputs
         // that line up exactly with the state register.
         busy <= (state_nx == SHIFT);
         done <= (state_nx == DONE);
         if (accept) begin
            sha   <= a;
            shb   <= b;
            carry <= cin;
            cnt   <= '0;
            acc   <= '0;
         end else if (state == SHIFT) begin
            carry <= bit_co;
            acc   <= {bit_s, acc[WIDTH-1:1]};
            sha   <= sha >> 1;
            shb   <= shb >> 1;
            cnt   <= cnt + CW'(1);
            // sum/cout only move on entry to DONE; the previous result stays
            // visible for the whole of a new operation.
            if (last) begin
               sum  <= {bit_s, acc[WIDTH-1:1]};
               cout <= bit_co;
            end
         end
      end
   end
endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
   localparam int W = 8;

   logic         clk, rst_n, start, cin;
   logic [W-1:0] a, b;
   logic         busy, done, cout;
   logic [W-1:0] sum;

   int n_vec  = 0;
   int n_fail = 0;

   // Reference-model view of what sum/cout should currently hold.
   logic [W-1:0] ref_sum;
   logic         ref_cout;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] s;
      logic         c;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Behavioural model: plain integer addition, modulo 2^(W+1).
   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic c);
      return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
   endfunction

   // Called at a negedge; start is accepted on the following posedge.
   task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      start = 1'b1; a = x; b = y; cin = c;
      @(posedge clk);
      #1;
      start = 1'b0;
      // Scramble inputs: captured operands must not follow them.
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
   endtask

   // Returns at the negedge of the done cycle. Checks latency, busy width,
   // that done stays low while busy, and that the old result is held.
   task automatic wait_done(input string name, input logic [W-1:0] xs, input logic xc);
      int lat = 0;
      int bcnt = 0;
      bit seen = 0;
      for (int i = 0; i < 3 * W; i++) begin
         @(negedge clk);
         lat++;
         if (done) begin
            seen = 1;
            break;
         end
         if (busy) bcnt++;
         chk({name, " held"}, {cout, sum}, {ref_cout, ref_sum});
      end
      chk({name, " done seen"}, 64'(seen), 64'd1);
      chk({name, " latency"}, 64'(lat), 64'(W + 1));
      chk({name, " busy cycles"}, 64'(bcnt), 64'(W));
      chk({name, " busy in done"}, 64'(busy), 64'd0);
      chk({name, " result"}, {cout, sum}, {xc, xs});
      ref_sum  = sum === xs ? xs : xs;
      ref_cout = xc;
   endtask

   task automatic idle_after(input string name);
      @(negedge clk);
      chk({name, " done 1 cycle"}, 64'(done), 64'd0);
      chk({name, " idle busy"}, 64'(busy), 64'd0);
   endtask

   vec_t tbl[8];

   initial begin
      logic [W:0] r;
      logic [W-1:0] ra, rb;
      logic rc;
      tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
      tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      tbl[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
      tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      tbl[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
      tbl[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      ref_sum = '0; ref_cout = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset outs", {busy, done, cout, sum}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle after reset", {busy, done}, 64'd0);

      // Directed table.
      for (int i = 0; i < 8; i++) begin
         launch(tbl[i].a, tbl[i].b, tbl[i].cin);
         wait_done($sformatf("tbl%0d", i), tbl[i].s, tbl[i].c);
         idle_after($sformatf("tbl%0d", i));
      end

      // Start pulsed mid-SHIFT must be ignored.
      launch(8'h12, 8'h34, 1'b0);
      repeat (3) @(negedge clk);
      start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      begin
         int lat = 4;
         bit seen = 0;
         for (int i = 0; i < 3 * W; i++) begin
            @(negedge clk);
            lat++;
            if (done) begin seen = 1; break; end
         end
         chk("ignore done seen", 64'(seen), 64'd1);
         chk("ignore latency", 64'(lat), 64'(W + 1));
         chk("ignore result", {cout, sum}, {1'b0, 8'h46});
         ref_sum = 8'h46; ref_cout = 1'b0;
      end
      repeat (W + 3) begin
         @(negedge clk);
         chk("ignore no extra op", {busy, done}, 64'd0);
      end

      // Back-to-back: start held in the done cycle.
      launch(8'h5A, 8'h3C, 1'b0);
      wait_done("b2b first", 8'h96, 1'b0);
      launch(8'h10, 8'h20, 1'b0);
      chk("b2b no gap", 64'(busy), 64'd1);
      wait_done("b2b second", 8'h30, 1'b0);
      idle_after("b2b");

      // Asynchronous reset at bit 4.
      launch(8'hC3, 8'h5D, 1'b1);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async reset outs", {busy, done, cout, sum}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ref_sum = '0; ref_cout = 1'b0;
      repeat (W + 3) begin
         @(negedge clk);
         chk("no done after reset", {busy, done}, 64'd0);
      end
      launch(8'hC3, 8'h5D, 1'b1);
      wait_done("post reset", 8'h21, 1'b1);
      idle_after("post reset");

      // Random sweep against the arithmetic model, mixing back-to-back and gaps.
      for (int i = 0; i < 1000; i++) begin
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         r = model(ra, rb, rc);
         launch(ra, rb, rc);
         wait_done("rand", r[W-1:0], r[W]);
         if ($urandom_range(0, 2) == 0) begin
            idle_after("rand");
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
